toy_multicycle_ctrl: RTL and testbench
======================================

// Module: toy_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the TOY CPU. It replaces the single-cycle decoder with a
//  FETCH/DECODE/EXEC/MEM/WB sequencer using a req/ack handshake to a shared instruction/data
//  memory. It keeps Z/C flags, resolves branches, and flags a sticky error on memory timeout.
//  Sits between the IR/datapath and the memory port.
// PARAMETERS
//  OP_W        4   opcode width (opcodes decoded on the low 4 bits; upper bits must be 0, else illegal)
//  TIMEOUT_W   4   width of memory wait counter
//  MEM_TIMEOUT 15  max cycles mem_req may wait for mem_ack (must fit TIMEOUT_W)
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous reset, active low
//  op        in   OP_W    opcode from IR (valid from DECODE onward)
//  alu_c     in   1       ALU carry, captured in EXEC of arithmetic ops
//  alu_z     in   1       ALU zero, captured in EXEC of arithmetic ops
//  mem_ack   in   1       memory completes current request (1-cycle pulse)
//  run       in   1       leave HALT on rising level (sampled in HALT only)
//  mem_req   out  1       memory request, held until ack or timeout
//  mem_we    out  1       request is a store (valid with mem_req)
//  ir_we     out  1       load IR (1-cycle pulse on fetch ack)
//  pc_we     out  1       update PC
//  pc_sel    out  1       0 = PC+1, 1 = branch/jump target
//  reg_we    out  1       register file write
//  wb_sel    out  2       00 ALU, 01 mem data, 10 PC+1 (link), 11 immediate
//  alu_op    out  3       000 add,001 sub,010 and,011 xor,100 shl,101 shr,110 pass-B
//  flag_c    out  1       registered carry flag
//  flag_z    out  1       registered zero flag
//  halted    out  1       FSM in HALT
//  err       out  1       sticky memory timeout / illegal opcode
//  state     out  3       current state encoding (debug)
// BEHAVIOUR
//  Reset: state=FETCH; all outputs 0; flags 0; err 0; wait counter 0. Async assert, sync release.
//  Encoding: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERROR=6. All outputs Moore except ir_we/pc_we
//    in FETCH and reg_we in WB, which are decoded from state + mem_ack.
//  FETCH: mem_req=1, mem_we=0; on mem_ack -> ir_we=1, pc_we=1, pc_sel=0 -> DECODE.
//  DECODE (1 cyc): 0 -> HALT; 1-6, 7 (load imm), C-F -> EXEC; 8-B -> MEM; op>=16 -> ERROR.
//  EXEC (1 cyc): ALU ops 1-6: reg_we=1, wb_sel=00, capture alu_c/alu_z; 7: reg_we, wb_sel=11;
//    C (BZ): pc_we=pc_sel=1 iff flag_z; D (BP): iff !flag_z & !flag_c; E (JR): pc_we=pc_sel=1;
//    F (JAL): reg_we, wb_sel=10, pc_we=pc_sel=1. -> FETCH.
//  MEM: mem_req=1, mem_we=1 for 9/B; on ack: loads (8,A) -> WB, stores -> FETCH.
//  WB (1 cyc): reg_we=1, wb_sel=01 -> FETCH.
//  Branch uses flags as registered before the EXEC edge; flags change only in EXEC of ops 1-6.
//  Timeout: counter clears on entry to FETCH/MEM, increments each cycle mem_req=1 && !mem_ack;
//    reaching MEM_TIMEOUT without ack -> ERROR, err=1. Ack in the same cycle wins over timeout.
//  HALT: all strobes 0, halted=1; on run=1 -> FETCH next cycle. ERROR: all strobes 0, err=1,
//    exits only via rst_n. mem_ack outside FETCH/MEM is ignored.
//  rst_n low mid-request drops mem_req immediately (async).
// STRUCTURE
//  Package toy_ctrl_pkg: state enum, opcode constants, alu_op/wb_sel encodings.
//  Sub-module toy_ctrl_timeout: wait counter + expiry compare (params TIMEOUT_W, MEM_TIMEOUT).
// TESTING
//  add: fetch ack in 2nd cycle, op=1, alu_z=1 -> ir_we@ack, reg_we 1 cyc in EXEC, flag_z=1, back to FETCH.
//  BZ: after sub with alu_z=1, op=C -> pc_we=pc_sel=1; repeat with flag_z=0 -> pc_we=0 in EXEC.
//  load: op=8, mem_ack after 3 cycles -> mem_req held 3 cyc, mem_we=0, WB reg_we=1, wb_sel=01.
//  timeout: no ack in FETCH -> err=1 after 15 wait cycles, state=6; ack on 15th cycle -> no err.
//  halt/run: op=0 -> halted=1, strobes 0; run=1 -> FETCH mem_req next cycle.
//  reset in MEM with mem_req=1 -> mem_req=0 same cycle, state=FETCH after release, flags 0.

Source files
------------

// File: rtl/toy_ctrl_pkg.sv
// Shared types and encodings for the TOY multi-cycle control sequencer.
package toy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BP   = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SHL   = 3'b100;
  localparam logic [2:0] ALU_SHR   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  function automatic logic is_alu(input logic [3:0] o);
    return (o >= 4'h1) && (o <= 4'h6);
  endfunction

  function automatic logic is_mem(input logic [3:0] o);
    return (o >= 4'h8) && (o <= 4'hB);
  endfunction

  function automatic logic [2:0] alu_sel(input logic [3:0] o);
    case (o)
      4'h1:    return ALU_ADD;
      4'h2:    return ALU_SUB;
      4'h3:    return ALU_AND;
      4'h4:    return ALU_XOR;
      4'h5:    return ALU_SHL;
      4'h6:    return ALU_SHR;
      default: return ALU_PASSB;
    endcase
  endfunction

endpackage

// File: rtl/toy_ctrl_timeout.sv
// Memory wait counter; expired pulses on the wait cycle that reaches MEM_TIMEOUT.
module toy_ctrl_timeout #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + TIMEOUT_W'(1);
  end

  // An ack in the final wait cycle drops inc, so the ack wins over expiry.
  assign expired = inc && (cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/toy_multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the TOY CPU with req/ack memory port,
// Z/C flags, branch resolution and sticky timeout / illegal-opcode error.
module toy_multicycle_ctrl
  import toy_ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            mem_ack,
  input  logic            run,
  output logic            mem_req,
  output logic            mem_we,
  output logic            ir_we,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic [2:0]      alu_op,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted,
  output logic            err,
  output logic [2:0]      state
);

  state_t      state_q;
  logic        pc_we_q;
  logic        fetch_ack;
  logic        mem_done;
  logic        expired;
  logic [31:0] op_ext;
  logic [3:0]  opc;
  logic        op_illegal;

  assign op_ext     = 32'(op);
  assign opc        = op_ext[3:0];
  assign op_illegal = |op_ext[31:4];

  // An ack only counts while a request is actually on the port.
  assign fetch_ack = (state_q == ST_FETCH) && mem_req && mem_ack;
  assign mem_done  = (state_q == ST_MEM) && mem_req && mem_ack;

  assign ir_we = fetch_ack;
  assign pc_we = pc_we_q | fetch_ack;
  assign state = state_q;

  toy_ctrl_timeout #(
    .TIMEOUT_W   (TIMEOUT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!mem_req || mem_ack),
    .inc     (mem_req && !mem_ack),
    .expired (expired)
  );

  // Outputs are registered from the next state, so each takes effect with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      pc_we_q <= 1'b0;
      pc_sel  <= 1'b0;
      reg_we  <= 1'b0;
      wb_sel  <= WB_ALU;
      alu_op  <= ALU_ADD;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      pc_we_q <= 1'b0;
      pc_sel  <= 1'b0;
      reg_we  <= 1'b0;
      wb_sel  <= WB_ALU;
      alu_op  <= ALU_ADD;
      halted  <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (fetch_ack) begin
            state_q <= ST_DECODE;
          end else if (expired) begin
            state_q <= ST_ERROR;
            err     <= 1'b1;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (op_illegal) begin
            state_q <= ST_ERROR;
            err     <= 1'b1;
          end else if (opc == OP_HALT) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end else if (is_mem(opc)) begin
            state_q <= ST_MEM;
            mem_req <= 1'b1;
            mem_we  <= opc[0];
          end else begin
            state_q <= ST_EXEC;
            alu_op  <= alu_sel(opc);
            if (is_alu(opc)) begin
              reg_we <= 1'b1;
              wb_sel <= WB_ALU;
            end else if (opc == OP_LDI) begin
              reg_we <= 1'b1;
              wb_sel <= WB_IMM;
            end else if (opc == OP_BZ) begin
              pc_we_q <= flag_z;
              pc_sel  <= flag_z;
            end else if (opc == OP_BP) begin
              pc_we_q <= !flag_z && !flag_c;
              pc_sel  <= !flag_z && !flag_c;
            end else if (opc == OP_JR) begin
              pc_we_q <= 1'b1;
              pc_sel  <= 1'b1;
            end else if (opc == OP_JAL) begin
              reg_we  <= 1'b1;
              wb_sel  <= WB_LINK;
              pc_we_q <= 1'b1;
              pc_sel  <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (is_alu(opc)) begin
            flag_c <= alu_c;
            flag_z <= alu_z;
          end
          state_q <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_MEM: begin
          if (mem_done) begin
            if (mem_we) begin
              state_q <= ST_FETCH;
              mem_req <= 1'b1;
            end else begin
              state_q <= ST_WB;
              reg_we  <= 1'b1;
              wb_sel  <= WB_MEM;
            end
          end else if (expired) begin
            state_q <= ST_ERROR;
            err     <= 1'b1;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= mem_we;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_HALT: begin
          if (run) begin
            state_q <= ST_FETCH;
            mem_req <= 1'b1;
          end else begin
            halted <= 1'b1;
          end
        end
        ST_ERROR: begin
          err <= 1'b1;
        end
        default: begin
          state_q <= ST_ERROR;
          err     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_multicycle_ctrl.sv
// Directed bench for toy_multicycle_ctrl with hand-computed expectations.
module tb_toy_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op = 4'h0;
  logic       alu_c = 1'b0;
  logic       alu_z = 1'b0;
  logic       mem_ack = 1'b0;
  logic       run = 1'b0;
  logic       mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0] wb_sel;
  logic [2:0] alu_op;
  logic       flag_c, flag_z, halted, err;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  toy_multicycle_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .alu_c   (alu_c),
    .alu_z   (alu_z),
    .mem_ack (mem_ack),
    .run     (run),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .ir_we   (ir_we),
    .pc_we   (pc_we),
    .pc_sel  (pc_sel),
    .reg_we  (reg_we),
    .wb_sel  (wb_sel),
    .alu_op  (alu_op),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .halted  (halted),
    .err     (err),
    .state   (state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Starts in FETCH with mem_req up; waits n cycles without ack, then acks.
  task automatic do_fetch(input int n);
    repeat (n) begin
      mem_ack = 1'b0;
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    check("fetch_ir_we", ir_we, 1);
    check("fetch_pc_we", pc_we, 1);
    check("fetch_pc_sel", pc_sel, 0);
    cyc();
    mem_ack = 1'b0;
    #1;
    check("decode_state", state, 1);
    check("decode_ir_we", ir_we, 0);
  endtask

  // From DECODE: one EXEC cycle then back to FETCH.
  task automatic exec_op(input string tag, input logic [3:0] o, input logic c, input logic z,
                         input logic [6:0] exp_ctl, input logic [2:0] exp_alu);
    op = o;
    alu_c = c;
    alu_z = z;
    cyc();
    check({tag, "_state"}, state, 2);
    check({tag, "_ctl"}, {reg_we, wb_sel, pc_we, pc_sel, mem_req, mem_we}, exp_ctl);
    check({tag, "_alu_op"}, alu_op, exp_alu);
    cyc();
    check({tag, "_back_fetch"}, {state, mem_req, reg_we, pc_we}, {3'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_state", state, 0);
    check("rst_outs", {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_op},
          11'd0);
    check("rst_flags", {flag_c, flag_z, halted, err}, 4'd0);
    #4 rst_n = 1'b1;
    cyc();
    check("first_fetch_req", {state, mem_req, mem_we}, {3'd0, 1'b1, 1'b0});

    // add: ack in second request cycle, zero result
    do_fetch(1);
    exec_op("add", 4'h1, 1'b0, 1'b1, 7'b1_00_00_00, 3'b000);
    check("add_flags", {flag_c, flag_z}, 2'b01);

    // sub (Z=1) then BZ taken
    do_fetch(0);
    exec_op("sub_z1", 4'h2, 1'b0, 1'b1, 7'b1_00_00_00, 3'b001);
    do_fetch(0);
    exec_op("bz_taken", 4'hC, 1'b1, 1'b0, 7'b0_00_11_00, 3'b110);
    check("bz_keeps_flags", {flag_c, flag_z}, 2'b01);

    // sub (Z=0) then BZ not taken, BP taken
    do_fetch(2);
    exec_op("sub_z0", 4'h2, 1'b0, 1'b0, 7'b1_00_00_00, 3'b001);
    check("sub_z0_flags", {flag_c, flag_z}, 2'b00);
    do_fetch(0);
    exec_op("bz_not", 4'hC, 1'b0, 1'b1, 7'b0_00_00_00, 3'b110);
    do_fetch(0);
    exec_op("bp_taken", 4'hD, 1'b0, 1'b0, 7'b0_00_11_00, 3'b110);
    do_fetch(0);
    exec_op("ldi", 4'h7, 1'b1, 1'b1, 7'b1_11_00_00, 3'b110);
    do_fetch(0);
    exec_op("jal", 4'hF, 1'b0, 1'b0, 7'b1_10_11_00, 3'b110);
    check("flags_after_nonalu", {flag_c, flag_z}, 2'b00);

    // load with ack in third MEM cycle
    do_fetch(0);
    op = 4'h8;
    cyc();
    check("ld_mem1", {state, mem_req, mem_we}, {3'd3, 1'b1, 1'b0});
    cyc();
    check("ld_mem2", {state, mem_req}, {3'd3, 1'b1});
    cyc();
    check("ld_mem3", {state, mem_req}, {3'd3, 1'b1});
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("ld_wb", {state, mem_req, reg_we, wb_sel}, {3'd4, 1'b0, 1'b1, 2'b01});
    cyc();
    check("ld_back_fetch", {state, mem_req, reg_we}, {3'd0, 1'b1, 1'b0});

    // store, immediate ack
    do_fetch(0);
    op = 4'h9;
    cyc();
    check("st_mem", {state, mem_req, mem_we}, {3'd3, 1'b1, 1'b1});
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("st_back_fetch", {state, mem_req, mem_we, reg_we}, {3'd0, 1'b1, 1'b0, 1'b0});

    // ack on the 15th wait cycle still wins
    do_fetch(14);
    check("late_ack_no_err", err, 0);

    // halt / run
    op = 4'h0;
    cyc();
    check("halt_state", {state, halted}, {3'd5, 1'b1});
    check("halt_strobes", {mem_req, mem_we, ir_we, pc_we, reg_we}, 5'd0);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("halt_stays", {state, halted, ir_we}, {3'd5, 1'b1, 1'b0});
    run = 1'b1;
    cyc();
    run = 1'b0;
    check("run_fetch", {state, mem_req, halted}, {3'd0, 1'b1, 1'b0});

    // set both flags, then reset in the middle of a load
    do_fetch(0);
    exec_op("and_cz", 4'h3, 1'b1, 1'b1, 7'b1_00_00_00, 3'b010);
    check("and_flags", {flag_c, flag_z}, 2'b11);
    do_fetch(0);
    op = 4'hA;
    cyc();
    check("ldx_mem", {state, mem_req, mem_we}, {3'd3, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_state", state, 0);
    check("rst_mid_flags", {flag_c, flag_z}, 2'b00);
    #8 rst_n = 1'b1;
    cyc();
    check("rel_fetch", {state, mem_req, err}, {3'd0, 1'b1, 1'b0});

    // timeout: 15 wait cycles without ack
    repeat (14) cyc();
    check("pre_timeout", {state, err, mem_req}, {3'd0, 1'b0, 1'b1});
    cyc();
    check("timeout_err", {state, err, mem_req}, {3'd6, 1'b1, 1'b0});
    mem_ack = 1'b1;
    run = 1'b1;
    #1;
    check("err_ignores_ack", {ir_we, pc_we}, 2'b00);
    cyc();
    mem_ack = 1'b0;
    run = 1'b0;
    check("err_sticky", {state, err, mem_req, halted}, {3'd6, 1'b1, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
